// File: rtl/pe_dot_sequencer_if.sv
// -----------------------------------------------------------------------------
// pe_dot_sequencer_if
//   Bundles the three streams around one PE dot-product sequencer:
//     operand stream  : s_valid / s_ready / s_activation / s_weight / s_last
//     PE drive        : pe_clear / pe_activation / pe_weight / pe_result
//     result stream   : res_valid / res_ready / res_data / res_count / res_trunc
//   master : the sequencer's view (drives s_ready, pe_*, res_*)
//   slave  : the environment's view (operand source, PE, result consumer)
// Parameters
//   BW       operand width; pe_result and res_data are 2*BW bits
//   MAX_LEN  max pairs per vector; sets the width of res_count
// -----------------------------------------------------------------------------
interface pe_dot_sequencer_if #(
  parameter int BW      = 8,
  parameter int MAX_LEN = 16
);
  localparam int DW = 2 * BW;
  localparam int CW = $clog2(MAX_LEN + 1);

  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_activation;
  logic [BW-1:0] s_weight;
  logic          s_last;

  logic          pe_clear;
  logic [BW-1:0] pe_activation;
  logic [BW-1:0] pe_weight;
  logic [DW-1:0] pe_result;

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [CW-1:0] res_count;
  logic          res_trunc;

  modport master (
    input  s_valid, s_activation, s_weight, s_last, pe_result, res_ready,
    output s_ready, pe_clear, pe_activation, pe_weight,
           res_valid, res_data, res_count, res_trunc
  );

  modport slave (
    output s_valid, s_activation, s_weight, s_last, pe_result, res_ready,
    input  s_ready, pe_clear, pe_activation, pe_weight,
           res_valid, res_data, res_count, res_trunc
  );
endinterface

// File: rtl/pe_dot_sequencer.sv
// -----------------------------------------------------------------------------
// pe_dot_sequencer
//   Initiator side of one PE. Clears the PE accumulator, streams accepted
//   (activation, weight) pairs into it, waits out the PE latency after the
//   final pair and presents the captured dot product on a valid/ready port.
// Ports
//   i_clock  : clock, all logic on the rising edge
//   i_reset  : synchronous reset, active-low
//   bus      : pe_dot_sequencer_if.master (operand, PE and result streams)
// Parameters
//   BW, MAX_LEN must match the interface instance; PE_LATENCY >= 1 is the
//   number of edges from operands on pe_* until pe_result includes them.
// -----------------------------------------------------------------------------
module pe_dot_sequencer #(
  parameter int BW         = 8,
  parameter int MAX_LEN    = 16,
  parameter int PE_LATENCY = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  pe_dot_sequencer_if.master    bus
);
  localparam int DW = 2 * BW;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int LW = $clog2(PE_LATENCY + 1);

  typedef enum logic [1:0] {CLEAR, STREAM, DRAIN, HOLD} state_e;

  state_e        state_q, state_d;
  logic          s_ready_q, s_ready_d;
  logic          pe_clear_q, pe_clear_d;
  logic [BW-1:0] pe_act_q, pe_act_d;
  logic [BW-1:0] pe_wgt_q, pe_wgt_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          trunc_q, trunc_d;
  logic [LW-1:0] drain_cnt_q, drain_cnt_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [CW-1:0] res_count_q, res_count_d;
  logic          res_trunc_q, res_trunc_d;

  logic          accept;
  logic [CW-1:0] beat_next;

  assign accept    = bus.s_valid & s_ready_q;
  assign beat_next = beat_cnt_q + 1'b1;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    pe_clear_d  = 1'b0;
    pe_act_d    = '0;  // PE sums zeros whenever no beat is being delivered
    pe_wgt_d    = '0;
    beat_cnt_d  = beat_cnt_q;
    trunc_d     = trunc_q;
    drain_cnt_d = drain_cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_trunc_d = res_trunc_q;

    case (state_q)
      // Reset lands here with pe_clear low, so the first edge out of reset
      // raises the clear pulse; the edge that sees it high moves on. This
      // makes the visible clear exactly one cycle both after reset and after
      // a result handshake (which raises pe_clear on its way in).
      CLEAR: begin
        beat_cnt_d  = '0;
        trunc_d     = 1'b0;
        drain_cnt_d = '0;
        if (!pe_clear_q) begin
          pe_clear_d = 1'b1;
        end else begin
          s_ready_d = 1'b1;
          state_d   = STREAM;
        end
      end

      STREAM: begin
        if (accept) begin
          pe_act_d   = bus.s_activation;
          pe_wgt_d   = bus.s_weight;
          beat_cnt_d = beat_next;
          if (bus.s_last || beat_next == CW'(MAX_LEN)) begin
            s_ready_d = 1'b0;
            trunc_d   = !bus.s_last;
            state_d   = DRAIN;
          end
        end
      end

      // The last beat sits on pe_* after the accepting edge; pe_result holds
      // it PE_LATENCY edges later, and it is sampled on the edge after that.
      DRAIN: begin
        if (drain_cnt_q == LW'(PE_LATENCY)) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.pe_result;
          res_count_d = beat_cnt_q;
          res_trunc_d = trunc_q;
          state_d     = HOLD;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          pe_clear_d  = 1'b1;
          state_d     = CLEAR;
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only (synchronous, active-low),
  // and all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= CLEAR;
      s_ready_q   <= 1'b0;
      pe_clear_q  <= 1'b0;
      pe_act_q    <= '0;
      pe_wgt_q    <= '0;
      beat_cnt_q  <= '0;
      trunc_q     <= 1'b0;
      drain_cnt_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      pe_clear_q  <= pe_clear_d;
      pe_act_q    <= pe_act_d;
      pe_wgt_q    <= pe_wgt_d;
      beat_cnt_q  <= beat_cnt_d;
      trunc_q     <= trunc_d;
      drain_cnt_q <= drain_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_trunc_q <= res_trunc_d;
    end
  end

  assign bus.s_ready       = s_ready_q;
  assign bus.pe_clear      = pe_clear_q;
  assign bus.pe_activation = pe_act_q;
  assign bus.pe_weight     = pe_wgt_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;
  assign bus.res_count     = res_count_q;
  assign bus.res_trunc     = res_trunc_q;
endmodule
